// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache refill paths for a single main-memory port.
// It runs one transaction at a time, gives a one-cycle ack and aborts stalled memory with a sticky error.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              grant_d,
  output logic              busy,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, ACK} state_t;

  state_t              state_q;
  logic                ic_ack_q, dc_ack_q, mem_req_q, mem_we_q;
  logic                last_grant_q, busy_q, mem_err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [LINE_W-1:0]   ic_rdata_q, dc_rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                timeout_hit_d;
  logic                done_d;
  logic [LINE_W-1:0]   line_d;
  logic                grant_dc_d;

  // A ready response in the limit cycle counts as a normal completion.
  assign timeout_hit_d = !mem_ready && (cnt_q == CNT_LAST);
  assign done_d        = mem_ready || timeout_hit_d;
  assign line_d        = mem_ready ? mem_rdata : '0;
  // On a tie the side that was not granted last wins.
  assign grant_dc_d    = dc_req && (!ic_req || !last_grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ic_ack_q     <= 1'b0;
      dc_ack_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_dc_d) begin
            state_q      <= MEM_D;
            mem_req_q    <= 1'b1;
            mem_we_q     <= dc_we;
            mem_addr_q   <= dc_addr;
            mem_wdata_q  <= dc_wdata;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
          end else if (ic_req) begin
            state_q      <= MEM_I;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= ic_addr;
            mem_wdata_q  <= '0;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
          end
        end
        MEM_I, MEM_D: begin
          if (!mem_ready && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (done_d) begin
            state_q   <= ACK;
            mem_req_q <= 1'b0;
            if (!mem_ready) begin
              mem_err_q <= 1'b1;
            end
            if (state_q == MEM_I) begin
              ic_ack_q   <= 1'b1;
              ic_rdata_q <= line_d;
            end else begin
              dc_ack_q <= 1'b1;
              if (!mem_we_q) begin
                dc_rdata_q <= line_d;
              end
            end
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ic_ack    = ic_ack_q;
  assign dc_ack    = dc_ack_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_d   = last_grant_q;
  assign busy      = busy_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks, a negedge monitor pops and compares them.
// The memory timeout is shortened to 4 cycles.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req, dc_req, dc_we, mem_ready;
  logic [31:0]  ic_addr, dc_addr, dc_wdata;
  logic [127:0] mem_rdata;
  logic         ic_ack, dc_ack, mem_req, mem_we, grant_d, busy, mem_err;
  logic [127:0] ic_rdata, dc_rdata;
  logic [31:0]  mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           isD;
    logic [127:0] data;
    bit           err;
  } exp_t;
  exp_t expQ[$];

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_d(grant_d), .busy(busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ic_ack || dc_ack) begin
      checkOutput("ackExclusive", 128'(ic_ack & dc_ack), 128'(0));
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedAck: got ic_ack=%0b dc_ack=%0b expected none", ic_ack, dc_ack);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("ackSide", 128'(dc_ack), 128'(e.isD));
        checkOutput("rdata", e.isD ? dc_rdata : ic_rdata, e.data);
        checkOutput("memErrAtAck", 128'(mem_err), 128'(e.err));
      end
    end
  end

  // One transaction: readyDelay < 0 means memory never answers; expLat counts cycles from grant to ack.
  task automatic applyStimulus(input bit isD, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int readyDelay,
                               input logic [127:0] rdata, input logic [127:0] expData,
                               input bit expErr, input int expLat);
    int lat;
    int waitN;
    exp_t e;
    e.isD = isD;
    e.data = expData;
    e.err = expErr;
    expQ.push_back(e);
    if (isD) begin
      dc_req = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wdata;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    tick();
    waitN = 0;
    while (!mem_req && waitN < 20) begin
      tick();
      waitN++;
    end
    checkOutput("memReqAtGrant", 128'(mem_req), 128'(1));
    checkOutput("memAddr", 128'(mem_addr), 128'(addr));
    checkOutput("memWe", 128'(mem_we), 128'(isD & we));
    checkOutput("grantD", 128'(grant_d), 128'(isD));
    checkOutput("busy", 128'(busy), 128'(1));
    if (isD && we) checkOutput("memWdata", 128'(mem_wdata), 128'(wdata));
    lat = 0;
    for (int n = 1; n <= 50; n++) begin
      mem_ready = (readyDelay >= 0) && (n - 1 == readyDelay);
      mem_rdata = rdata;
      tick();
      mem_ready = 1'b0;
      if (isD ? dc_ack : ic_ack) begin
        lat = n;
        break;
      end
    end
    checkOutput("ackLatency", 128'(lat), 128'(expLat));
    checkOutput("memReqInAck", 128'(mem_req), 128'(0));
    tick();
    if (isD) dc_req = 1'b0;
    else ic_req = 1'b0;
    checkOutput("ackOnePulse", 128'(ic_ack | dc_ack), 128'(0));
  endtask

  localparam logic [127:0] LINE_A = 128'hDEAD0000_11112222_33334444_0000BEEF;
  localparam logic [127:0] LINE_B = 128'hA5A5A5A5_00000001_CAFEF00D_12345678;
  localparam logic [127:0] LINE_C = 128'h0F0F0F0F_F0F0F0F0_76543210_89ABCDEF;
  localparam logic [127:0] LINE_D = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] LINE_E = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] JUNK   = {4{32'hFFFF_FFFF}};

  initial begin
    rst = 1'b1;
    ic_req = 0; dc_req = 0; dc_we = 0; mem_ready = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rstMemReq", 128'(mem_req), 128'(0));
    checkOutput("rstBusy", 128'(busy), 128'(0));
    checkOutput("rstGrantD", 128'(grant_d), 128'(0));
    checkOutput("rstMemErr", 128'(mem_err), 128'(0));
    checkOutput("rstMemAddr", 128'(mem_addr), 128'(0));
    checkOutput("rstIcRdata", ic_rdata, 128'(0));
    checkOutput("rstDcRdata", dc_rdata, 128'(0));

    // Plain I-cache refill, memory answers two cycles after mem_req rises.
    applyStimulus(0, 0, 32'h0000_0040, 32'h0, 2, LINE_A, LINE_A, 0, 3);

    // Tie: both held; last grant was I, so D goes first, then I, then D again on the next tie.
    ic_req = 1'b1; ic_addr = 32'h0000_0200;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0300;
    applyStimulus(1, 0, 32'h0000_0300, 32'h0, 0, LINE_B, LINE_B, 0, 1);
    applyStimulus(0, 0, 32'h0000_0200, 32'h0, 1, LINE_C, LINE_C, 0, 2);
    ic_req = 1'b1; ic_addr = 32'h0000_0400;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0500;
    applyStimulus(1, 0, 32'h0000_0500, 32'h0, 0, LINE_D, LINE_D, 0, 1);
    applyStimulus(0, 0, 32'h0000_0400, 32'h0, 0, LINE_E, LINE_E, 0, 1);

    // Word write: dc_rdata must keep the previous D line despite junk on mem_rdata.
    applyStimulus(1, 1, 32'h0000_0100, 32'h1234_5678, 0, JUNK, LINE_D, 0, 1);

    // Ready arrives in the limit cycle: normal completion with real data.
    applyStimulus(0, 0, 32'h0000_0600, 32'h0, 3, LINE_B, LINE_B, 0, 4);
    checkOutput("noErrOnLateReady", 128'(mem_err), 128'(0));

    // Memory never answers: aborted after four MEM cycles, data zeroed, sticky error.
    applyStimulus(1, 0, 32'h0000_0700, 32'h0, -1, LINE_C, 128'(0), 1, 4);
    checkOutput("memErrSet", 128'(mem_err), 128'(1));
    applyStimulus(0, 0, 32'h0000_0800, 32'h0, 0, LINE_D, LINE_D, 1, 1);
    checkOutput("memErrSticky", 128'(mem_err), 128'(1));

    // Reset while MEM_I is outstanding: no ack, then the held request is re-granted.
    ic_req = 1'b1; ic_addr = 32'h0000_0900;
    tick();
    checkOutput("preRstMemReq", 128'(mem_req), 128'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abortMemReq", 128'(mem_req), 128'(0));
    checkOutput("abortBusy", 128'(busy), 128'(0));
    checkOutput("abortIcAck", 128'(ic_ack), 128'(0));
    checkOutput("abortMemErr", 128'(mem_err), 128'(0));
    applyStimulus(0, 0, 32'h0000_0900, 32'h0, 1, LINE_A, LINE_A, 0, 2);

    tick();
    tick();
    checkOutput("scoreboardDrained", 128'(expQ.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
